// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bus between the F/M arbiter (master) and the memory (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemReady;
  logic [DATA_W-1:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemReady, MemRData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (F) and memory stage (M), one transaction at a time.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_IBUF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               IReq,
  input  logic [ADDR_W-1:0]  IAddr,
  input  logic               DReq,
  input  logic               DWe,
  input  logic [ADDR_W-1:0]  DAddr,
  input  logic [DATA_W-1:0]  DWData,
  mem_port_arbiter_if.master mem,
  output logic               IDone,
  output logic [DATA_W-1:0]  IRData,
  output logic               DDone,
  output logic [DATA_W-1:0]  DRData,
  output logic               StallFetch,
  output logic               StallMem
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, stateNext;
  logic              eReqI, eReqD;
  logic              grantI, grantD;
  logic [3:0]        starveCnt;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;

  // A requester still holding its request during its own done pulse is not a new request.
  assign eReqI      = IReq & ~IDone;
  assign eReqD      = DReq & ~DDone;
  assign StallFetch = eReqI;
  assign StallMem   = eReqD;

  assign mem.MemReq   = (state != IDLE);
  assign mem.MemWe    = memWe;
  assign mem.MemAddr  = memAddr;
  assign mem.MemWData = memWData;

`ifdef MEM_ARB_IBUF_EN
  logic              bufValid;
  logic [ADDR_W-1:0] bufTag;
  logic [DATA_W-1:0] bufData;
  logic              bufHit;
  logic              ibufHit;

  assign bufHit = bufValid && (IAddr == bufTag);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      bufValid <= 1'b0;
      bufTag   <= '0;
      bufData  <= '0;
    end else if (state == IBUSY && mem.MemReady) begin
      bufValid <= 1'b1;
      bufTag   <= memAddr;
      bufData  <= mem.MemRData;
    end else if (state == DBUSY && mem.MemReady && memWe && memAddr == bufTag) begin
      bufValid <= 1'b0;
    end
  end
`endif

  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
`ifdef MEM_ARB_IBUF_EN
    ibufHit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (eReqD && (!eReqI || starveCnt != LIMIT)) begin
          grantD    = 1'b1;
          stateNext = DBUSY;
        end else if (eReqI) begin
`ifdef MEM_ARB_IBUF_EN
          if (bufHit) ibufHit = 1'b1;
          else
`endif
          begin
            grantI    = 1'b1;
            stateNext = IBUSY;
          end
        end
      end
      IBUSY, DBUSY: begin
        if (mem.MemReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      IDone     <= 1'b0;
      DDone     <= 1'b0;
      IRData    <= '0;
      DRData    <= '0;
      starveCnt <= '0;
    end else begin
      IDone <= 1'b0;
      DDone <= 1'b0;
      // Bus fields are latched once at grant and held for the whole transaction.
      if (grantD) begin
        memAddr  <= DAddr;
        memWe    <= DWe;
        memWData <= DWData;
      end
      if (grantI) begin
        memAddr <= IAddr;
        memWe   <= 1'b0;
      end
      if (state == IBUSY && mem.MemReady) begin
        IRData <= mem.MemRData;
        IDone  <= 1'b1;
      end
      if (state == DBUSY && mem.MemReady) begin
        DDone <= 1'b1;
        if (!memWe) DRData <= mem.MemRData;
      end
`ifdef MEM_ARB_IBUF_EN
      if (ibufHit) begin
        IDone  <= 1'b1;
        IRData <= bufData;
      end
`endif
      if (!IReq || grantI)                     starveCnt <= '0;
      else if (grantD && starveCnt < LIMIT)    starveCnt <= starveCnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, randomized run against a transaction model.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWData;
  logic        IDone, DDone, StallFetch, StallMem;
  logic [31:0] IRData, DRData;

  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .mem(mif.master),
    .IDone(IDone), .IRData(IRData), .DDone(DDone), .DRData(DRData),
    .StallFetch(StallFetch), .StallMem(StallMem)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          isD;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          readyCycle;
    logic [31:0] rdata;
    logic        expWe;
    logic [31:0] expRData;
  } txn_t;

  txn_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Starts at 1 time unit after a rising edge with the arbiter idle.
  task automatic runTxn(input txn_t t);
    if (t.isD) begin
      DReq = 1'b1; DWe = t.we; DAddr = t.addr; DWData = t.wdata;
    end else begin
      IReq = 1'b1; IAddr = t.addr;
    end
    mif.MemReady = 1'b0;
    mif.MemRData = t.rdata;
    @(negedge Clk);
    chk("txn idle MemReq", mif.MemReq, 1'b0);
    chk("txn stall on request", t.isD ? StallMem : StallFetch, 1'b1);
    tick;
    for (int b = 1; b <= t.readyCycle; b++) begin
      mif.MemReady = (b == t.readyCycle);
      @(negedge Clk);
      chk("txn busy MemReq", mif.MemReq, 1'b1);
      chk("txn busy MemAddr", mif.MemAddr, t.addr);
      chk("txn busy MemWe", mif.MemWe, t.expWe);
      if (t.expWe) chk("txn busy MemWData", mif.MemWData, t.wdata);
      chk("txn done early", t.isD ? DDone : IDone, 1'b0);
      tick;
    end
    mif.MemReady = 1'b0;
    @(negedge Clk);
    chk("txn done pulse", t.isD ? DDone : IDone, 1'b1);
    chk("txn rdata", t.isD ? DRData : IRData, t.expRData);
    chk("txn MemReq after", mif.MemReq, 1'b0);
    chk("txn stall after", t.isD ? StallMem : StallFetch, 1'b0);
    tick;
    IReq = 1'b0;
    DReq = 1'b0;
    @(negedge Clk);
    chk("txn done single", t.isD ? DDone : IDone, 1'b0);
    chk("txn no regrant", mif.MemReq, 1'b0);
    tick;
  endtask

  // Transaction-level reference: who owns the port, what was latched, what is being returned.
  int          mOwner;
  int          mCnt;
  logic [31:0] mAddr, mWData, mIR, mDR, mBufTag, mBufData;
  logic        mWe, mID, mDD, mBufV;

  task automatic mReset;
    mOwner = 0; mCnt = 0; mAddr = '0; mWData = '0; mIR = '0; mDR = '0;
    mWe = 1'b0; mID = 1'b0; mDD = 1'b0; mBufV = 1'b0; mBufTag = '0; mBufData = '0;
  endtask

  task automatic mStep;
    logic nID, nDD;
    bit   wantI, wantD, fGrant;
    nID = 1'b0; nDD = 1'b0; fGrant = 1'b0;
    wantI = IReq && !mID;
    wantD = DReq && !mDD;
    if (mOwner == 0) begin
      if (wantD && (!wantI || mCnt != STARVE_LIMIT)) begin
        mOwner = 2; mAddr = DAddr; mWe = DWe; mWData = DWData;
        if (IReq && mCnt < STARVE_LIMIT) mCnt = mCnt + 1;
      end else if (wantI) begin
`ifdef MEM_ARB_IBUF_EN
        if (mBufV && mBufTag == IAddr) begin
          nID = 1'b1; mIR = mBufData;
        end else
`endif
        begin
          mOwner = 1; mAddr = IAddr; mWe = 1'b0; fGrant = 1'b1;
        end
      end
    end else if (mif.MemReady) begin
      if (mOwner == 1) begin
        nID = 1'b1; mIR = mif.MemRData;
        mBufV = 1'b1; mBufTag = mAddr; mBufData = mif.MemRData;
      end else begin
        nDD = 1'b1;
        if (!mWe) mDR = mif.MemRData;
        else if (mAddr == mBufTag) mBufV = 1'b0;
      end
      mOwner = 0;
    end
    if (!IReq || fGrant) mCnt = 0;
    mID = nID;
    mDD = nDD;
  endtask

  initial begin
    logic        grants[$];
    int          fn;
    txn_t        t;

    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 2, 32'hAAAA5555, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 32'h200, 32'h0,        1, 32'h8C220004, 1'b0, 32'h8C220004};
    tbl[3] = '{1'b1, 1'b0, 32'h104, 32'h0,        1, 32'h00000001, 1'b0, 32'h00000001};
    tbl[4] = '{1'b0, 1'b0, 32'h204, 32'h0,        4, 32'h20420001, 1'b0, 32'h20420001};

    ResetN = 1'b0; IReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
    IAddr = '0; DAddr = '0; DWData = '0;
    mif.MemReady = 1'b0; mif.MemRData = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset MemReq", mif.MemReq, 1'b0);
    chk("reset MemWe", mif.MemWe, 1'b0);
    chk("reset MemAddr", mif.MemAddr, 32'h0);
    chk("reset MemWData", mif.MemWData, 32'h0);
    chk("reset IDone", IDone, 1'b0);
    chk("reset DDone", DDone, 1'b0);
    chk("reset IRData", IRData, 32'h0);
    chk("reset DRData", DRData, 32'h0);
    chk("reset StallFetch", StallFetch, 1'b0);
    chk("reset StallMem", StallMem, 1'b0);
    ResetN = 1'b1;
    mif.MemReady = 1'b1;
    @(negedge Clk);
    chk("ready ignored in idle", mif.MemReq, 1'b0);
    tick;
    @(negedge Clk);
    chk("ready ignored no done", IDone | DDone, 1'b0);
    tick;
    mif.MemReady = 1'b0;

    for (int i = 0; i < 5; i++) runTxn(tbl[i]);

    // Simultaneous requests with zero wait states.
    IReq = 1'b1; IAddr = 32'h300; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h108;
    mif.MemReady = 1'b1; mif.MemRData = 32'h11;
    @(negedge Clk);
    chk("sim idle MemReq", mif.MemReq, 1'b0);
    chk("sim StallFetch", StallFetch, 1'b1);
    chk("sim StallMem", StallMem, 1'b1);
    tick;
    @(negedge Clk);
    chk("sim D first", mif.MemAddr, 32'h108);
    chk("sim D busy", mif.MemReq, 1'b1);
    tick;
    mif.MemRData = 32'h22;
    DReq = 1'b0;
    @(negedge Clk);
    chk("sim DDone", DDone, 1'b1);
    chk("sim DRData", DRData, 32'h11);
    chk("sim idle between", mif.MemReq, 1'b0);
    chk("sim StallFetch held", StallFetch, 1'b1);
    tick;
    @(negedge Clk);
    chk("sim F granted", mif.MemAddr, 32'h300);
    chk("sim F busy", mif.MemReq, 1'b1);
    chk("sim F we", mif.MemWe, 1'b0);
    chk("sim IDone early", IDone, 1'b0);
    tick;
    @(negedge Clk);
    chk("sim IDone", IDone, 1'b1);
    chk("sim IRData", IRData, 32'h22);
    tick;
    IReq = 1'b0;
    mif.MemReady = 1'b0;
    @(negedge Clk);
    chk("sim IDone single", IDone, 1'b0);
    tick;

    // Both requesters held continuously: the done mask hands the port over on every done cycle.
    IReq = 1'b1; IAddr = 32'h400; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h500;
    mif.MemReady = 1'b1; mif.MemRData = 32'h33;
    fn = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (mif.MemReq) grants.push_back(mif.MemAddr == 32'h500);
      if (IDone) begin
        fn++;
        IAddr = 32'h400 + (32'(fn) << 2);
      end
      tick;
    end
    IReq = 1'b0; DReq = 1'b0;
    tick; tick;
    mif.MemReady = 1'b0;
    chk("alt grant count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++)
      chk("alt grant owner", {31'b0, grants[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);

    // Reset while a store is in flight.
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h600; DWData = 32'hCAFEF00D;
    tick;
    @(negedge Clk);
    chk("rst busy MemReq", mif.MemReq, 1'b1);
    chk("rst busy MemWe", mif.MemWe, 1'b1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("rst async MemReq", mif.MemReq, 1'b0);
    chk("rst async MemWe", mif.MemWe, 1'b0);
    chk("rst async MemAddr", mif.MemAddr, 32'h0);
    chk("rst async MemWData", mif.MemWData, 32'h0);
    chk("rst async DRData", DRData, 32'h0);
    chk("rst async IRData", IRData, 32'h0);
    chk("rst async dones", {30'b0, IDone, DDone}, 32'h0);
    DReq = 1'b0; DWe = 1'b0;
    @(posedge Clk);
    #1;
    ResetN = 1'b1;
    @(negedge Clk);
    chk("rst release idle", mif.MemReq, 1'b0);
    tick;
    t = '{1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h0BADF00D, 1'b0, 32'h0BADF00D};
    runTxn(t);

`ifdef MEM_ARB_IBUF_EN
    t = '{1'b0, 1'b0, 32'h200, 32'h0, 2, 32'h8C010200, 1'b0, 32'h8C010200};
    runTxn(t);
    IReq = 1'b1; IAddr = 32'h200;
    @(negedge Clk);
    chk("ibuf hit idle", mif.MemReq, 1'b0);
    tick;
    @(negedge Clk);
    chk("ibuf hit IDone", IDone, 1'b1);
    chk("ibuf hit IRData", IRData, 32'h8C010200);
    chk("ibuf hit no MemReq", mif.MemReq, 1'b0);
    tick;
    IReq = 1'b0;
    @(negedge Clk);
    chk("ibuf hit single", IDone, 1'b0);
    tick;
    t = '{1'b1, 1'b1, 32'h200, 32'h55AA55AA, 1, 32'h0, 1'b1, 32'h0BADF00D};
    runTxn(t);
    t = '{1'b0, 1'b0, 32'h200, 32'h0, 1, 32'h8C020200, 1'b0, 32'h8C020200};
    runTxn(t);
`endif

    // Randomized traffic against the reference model.
    ResetN = 1'b0;
    IReq = 1'b0; DReq = 1'b0; mif.MemReady = 1'b0;
    tick;
    ResetN = 1'b1;
    mReset();
    for (int n = 0; n < 2000; n++) begin
      if (!IReq) begin
        IReq  = ($urandom_range(0, 3) == 0);
        IAddr = 32'h200 + (32'($urandom_range(0, 3)) << 2);
      end else if (mID) begin
        IReq = $urandom_range(0, 1) == 1;
        if (IReq) IAddr = 32'h200 + (32'($urandom_range(0, 3)) << 2);
      end else if ($urandom_range(0, 31) == 0) begin
        IReq = 1'b0;
      end
      if (!DReq || mDD) begin
        DReq   = (!DReq) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        DWe    = $urandom_range(0, 1) == 1;
        DWData = $urandom;
        DAddr  = ($urandom_range(0, 4) == 4) ? 32'h100 : 32'h200 + (32'($urandom_range(0, 3)) << 2);
      end else if ($urandom_range(0, 31) == 0) begin
        DReq = 1'b0;
      end
      mif.MemReady = ($urandom_range(0, 2) == 0);
      mif.MemRData = $urandom;
      @(negedge Clk);
      chk("rnd MemReq", mif.MemReq, mOwner != 0);
      chk("rnd MemAddr", mif.MemAddr, mAddr);
      chk("rnd MemWe", mif.MemWe, mWe);
      if (mOwner == 2 && mWe) chk("rnd MemWData", mif.MemWData, mWData);
      chk("rnd IDone", IDone, mID);
      chk("rnd DDone", DDone, mDD);
      chk("rnd IRData", IRData, mIR);
      chk("rnd DRData", DRData, mDR);
      chk("rnd StallFetch", StallFetch, IReq && !mID);
      chk("rnd StallMem", StallMem, DReq && !mDD);
      @(posedge Clk);
      mStep();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
